// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared types and helpers for the sequential magnitude comparator
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One-hot result encoding, ordered {l, e, g}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_compare.sv
// rtl/digit_compare.sv - combinational unsigned compare of one DIGIT-wide chunk
module digit_compare #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             lt,
  output logic             gt
);

  assign lt = (x < y);
  assign gt = (x > y);

endmodule

// File: rtl/sequential_magnitude_comparator.sv
// rtl/sequential_magnitude_comparator.sv - MSB-first multi-cycle compare with early exit
module sequential_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CW     = clog2(NCHUNK + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       res_q, res_d;
  logic             chunk_lt, chunk_gt;

  digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
    .x  (sa_q[WIDTH-1 -: DIGIT]),
    .y  (sb_q[WIDTH-1 -: DIGIT]),
    .lt (chunk_lt),
    .gt (chunk_gt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Flipping both sign bits maps two's-complement order onto unsigned order
          sa_d              = a;
          sb_d              = b;
          sa_d[WIDTH-1]     = a[WIDTH-1] ^ is_signed;
          sb_d[WIDTH-1]     = b[WIDTH-1] ^ is_signed;
          res_d             = RES_NONE;
          cnt_d             = CW'(NCHUNK);
          state_d           = RUN;
        end
      end
      RUN: begin
        if (chunk_gt) begin
          res_d   = RES_GT;
          state_d = DONE;
        end else if (chunk_lt) begin
          res_d   = RES_LT;
          state_d = DONE;
        end else if (cnt_q == CW'(1)) begin
          res_d   = RES_EQ;
          state_d = DONE;
        end else begin
          sa_d  = sa_q << DIGIT;
          sb_d  = sb_q << DIGIT;
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign {l, e, g} = res_q;

endmodule

// File: tb/tb_sequential_magnitude_comparator.sv
// tb/tb_sequential_magnitude_comparator.sv - bench for the sequential magnitude comparator
module tb_sequential_magnitude_comparator;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic        clk;
  logic        rst;
  logic [31:0] a, b;
  logic        is_signed;
  logic        start;
  logic        busy1, done1, l1, e1, g1;
  logic        busy4, done4, l4, e4, g4;

  int compared;
  int mismatched;

  sequential_magnitude_comparator #(.WIDTH(32), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .is_signed(is_signed), .start(start),
    .busy(busy1), .done(done1), .l(l1), .e(e1), .g(g1)
  );

  sequential_magnitude_comparator #(.WIDTH(32), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .is_signed(is_signed), .start(start),
    .busy(busy4), .done(done4), .l(l4), .e(e4), .g(g4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [2:0]  res;
    int          n1;
    int          n4;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model_res(input logic [31:0] x, input logic [31:0] y, input logic sgn);
    if (sgn) begin
      if ($signed(x) < $signed(y)) return LT;
      if ($signed(x) > $signed(y)) return GT;
      return EQ;
    end
    if (x < y) return LT;
    if (x > y) return GT;
    return EQ;
  endfunction

  // 1-based index of the first differing DIGIT-wide chunk from the MSB
  function automatic int model_n(input logic [31:0] x, input logic [31:0] y, input int d);
    logic [31:0] diff;
    int p;
    diff = x ^ y;
    if (diff == 0) return 32 / d;
    p = 31;
    while (!diff[p]) p--;
    return (31 - p) / d + 1;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sg, input logic [2:0] er, input int en1, input int en4);
    int   n1, n4;
    bit   d1, d4, bad;
    logic [2:0] r1, r4;
    a = av; b = bv; is_signed = sg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n1 = 0; n4 = 0; d1 = 0; d4 = 0; bad = 0; r1 = '0; r4 = '0;
    for (int c = 0; c < 100 && !(d1 && d4); c++) begin
      if (!d1) begin
        if (done1) begin d1 = 1; r1 = {l1, e1, g1}; end
        else if (busy1) begin n1++; if ({l1, e1, g1} != 3'b000) bad = 1; end
      end
      if (!d4) begin
        if (done4) begin d4 = 1; r4 = {l4, e4, g4}; end
        else if (busy4) begin n4++; if ({l4, e4, g4} != 3'b000) bad = 1; end
      end
      if (!(d1 && d4)) @(negedge clk);
    end
    chk({tag, " done_seen"}, {31'd0, d1 && d4}, 32'd1);
    chk({tag, " res_d1"}, {29'd0, r1}, {29'd0, er});
    chk({tag, " res_d4"}, {29'd0, r4}, {29'd0, er});
    chk({tag, " lat_d1"}, n1, en1);
    chk({tag, " lat_d4"}, n4, en4);
    chk({tag, " clear_while_busy"}, {31'd0, bad}, 32'd0);
    @(negedge clk);
    chk({tag, " hold_d1"}, {29'd0, l1, e1, g1}, {29'd0, er});
    chk({tag, " hold_d4"}, {29'd0, l4, e4, g4}, {29'd0, er});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          cnt;
    bit          flag;

    compared = 0; mismatched = 0;
    a = '0; b = '0; is_signed = 0; start = 0;
    rst = 1'b0;

    vecs[0]  = '{32'd50,        32'd50,        1'b0, EQ, 32, 8};
    vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, GT, 1,  1};
    vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, LT, 1,  1};
    vecs[3]  = '{32'h1234_5678, 32'h1234_5679, 1'b0, LT, 32, 8};
    vecs[4]  = '{32'hF000_0000, 32'h0FFF_FFFF, 1'b0, GT, 1,  1};
    vecs[5]  = '{32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b1, LT, 30, 8};
    vecs[6]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, GT, 30, 8};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, EQ, 32, 8};
    vecs[8]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, GT, 1,  1};
    vecs[9]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, LT, 1,  1};
    vecs[10] = '{32'h0000_0010, 32'h0000_0000, 1'b0, GT, 28, 7};

    repeat (3) @(negedge clk);
    chk("reset_outputs_d1", {27'd0, busy1, done1, l1, e1, g1}, 32'd0);
    chk("reset_outputs_d4", {27'd0, busy4, done4, l4, e4, g4}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
             vecs[i].res, vecs[i].n1, vecs[i].n4);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: rb = $urandom;
        1: rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = ra;
      endcase
      run_op($sformatf("rnd%0d", i), ra, rb, rs, model_res(ra, rb, rs),
             model_n(ra, rb, 1), model_n(ra, rb, 4));
    end

    // Start pulses during RUN and during DONE must be ignored
    a = 32'd50; b = 32'd50; is_signed = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    repeat (4) begin @(negedge clk); cnt++; end
    a = 32'd0; b = 32'd1; start = 1'b1;
    @(negedge clk); cnt++;
    start = 1'b0;
    for (int c = 0; c < 64 && !done1; c++) begin
      @(negedge clk);
      if (!done1) cnt++;
    end
    chk("ignore_done_seen", {31'd0, done1}, 32'd1);
    chk("ignore_latency", cnt, 32);
    chk("ignore_result", {29'd0, l1, e1, g1}, {29'd0, EQ});
    a = 32'd1; b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignore_in_done_busy", {30'd0, busy1, done1}, 32'd0);
    chk("ignore_in_done_hold", {29'd0, l1, e1, g1}, {29'd0, EQ});
    @(negedge clk);
    chk("ignore_not_queued", {31'd0, busy1}, 32'd0);
    repeat (12) @(negedge clk);
    run_op("restart", 32'd3, 32'd9, 1'b0, LT, 29, 8);

    // Asynchronous reset in the middle of RUN
    a = 32'd50; b = 32'd50; is_signed = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_d1", {27'd0, busy1, done1, l1, e1, g1}, 32'd0);
    chk("abort_d4", {27'd0, busy4, done4, l4, e4, g4}, 32'd0);
    flag = 0;
    repeat (4) begin @(negedge clk); if (done1 || done4) flag = 1; end
    rst = 1'b1;
    repeat (3) begin @(negedge clk); if (done1 || done4) flag = 1; end
    chk("abort_no_done", {31'd0, flag}, 32'd0);
    run_op("after_abort", 32'hFFFF_0000, 32'hFFFF_0000, 1'b1, EQ, 32, 8);

    // Start held high: one operation every n+2 cycles
    a = 32'h10; b = 32'h0; is_signed = 0; start = 1'b1;
    for (int c = 0; c < 100 && !done1; c++) @(negedge clk);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cnt++;
      if (done1) break;
    end
    chk("b2b_period", cnt, 30);
    chk("b2b_result", {29'd0, l1, e1, g1}, {29'd0, GT});
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
